// File: rtl/tx_pkg.sv
// Shared types, buffer geometry and pointer arithmetic for the transmit drain path.
package tx_pkg;

    localparam int unsigned TXBUF_DEPTH     = 200001;
    localparam int unsigned TXBUF_AW        = 20;
    localparam int unsigned CLK_PER_BIT_DEF = 868;

    // Serializer phases; FETCH is the drain's one-cycle read step.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // Drain controller view: idle, reading the buffer, or a frame in the serializer.
    typedef enum logic [1:0] {
        DR_IDLE,
        DR_FETCH,
        DR_SEND
    } drain_t;

    // Advance a buffer pointer, wrapping at the last entry rather than at 2^AW.
    function automatic logic [TXBUF_AW-1:0] ptr_inc(input logic [TXBUF_AW-1:0] p,
                                                     input logic [TXBUF_AW-1:0] last);
        return (p == last) ? '0 : p + TXBUF_AW'(1);
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: start pulse loads a byte, done_c pulses in the last STOP cycle.
module uart_tx_core
    import tx_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done_c
);

    localparam int unsigned BW = $clog2(CLK_PER_BIT);

    state_t         state, state_n;
    logic [7:0]     shreg, shreg_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic [BW-1:0]  baud, baud_n;
    logic           txd_n;
    logic           last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            baud    <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            baud    <= baud_n;
            txd     <= txd_n;
        end
    end

    // txd_n is the level for the next cycle, so txd comes straight from a flop.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        baud_n    = baud;
        txd_n     = txd;
        done_c    = 1'b0;
        last      = (baud == BW'(CLK_PER_BIT - 1));

        case (state)
            ST_IDLE: begin
                txd_n = 1'b1;
                if (start) begin
                    state_n = ST_START;
                    shreg_n = data;
                    baud_n  = '0;
                    txd_n   = 1'b0;
                end
            end
            ST_START: begin
                if (last) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                    txd_n     = shreg[0];
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            ST_DATA: begin
                if (last) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        txd_n     = shreg[bit_idx + 3'd1];
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            ST_STOP: begin
                if (last) begin
                    baud_n  = '0;
                    state_n = ST_IDLE;
                    done_c  = 1'b1;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/tx_drain.sv
// Drains the byte transmit buffer onto the UART line; owns the read pointer and flags.
module tx_drain
    import tx_pkg::*;
#(
    parameter int unsigned DEPTH       = TXBUF_DEPTH,
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int unsigned AW          = TXBUF_AW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [AW-1:0] wptr,
    output logic [AW-1:0] ra,
    input  logic [7:0]    rd,
    output logic          txd,
    output logic          busy,
    output logic          empty,
    output logic          full
);

    localparam logic [TXBUF_AW-1:0] LAST = TXBUF_AW'(DEPTH - 1);

    drain_t         state, state_n;
    logic [AW-1:0]  rptr;
    logic [AW-1:0]  rptr_inc;
    logic [AW-1:0]  wptr_inc;
    logic           busy_n;
    logic           start_c;
    logic           done_c;

    // Pointers are AW wide; the package helper works at buffer width.
    assign rptr_inc = AW'(ptr_inc(TXBUF_AW'(rptr), LAST));
    assign wptr_inc = AW'(ptr_inc(TXBUF_AW'(wptr), LAST));

    assign ra    = rptr;
    assign empty = (rptr == wptr);
    assign full  = (wptr_inc == rptr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= DR_IDLE;
            rptr  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
            if (state == DR_FETCH) begin
                rptr <= rptr_inc;
            end
        end
    end

    // The STOP-end decision reuses the serializer's done_c so back-to-back costs one FETCH cycle.
    always_comb begin
        state_n = state;
        start_c = 1'b0;

        case (state)
            DR_IDLE: begin
                if (en && !empty) begin
                    state_n = DR_FETCH;
                end
            end
            DR_FETCH: begin
                start_c = 1'b1;
                state_n = DR_SEND;
            end
            DR_SEND: begin
                if (done_c) begin
                    state_n = (en && !empty) ? DR_FETCH : DR_IDLE;
                end
            end
            default: state_n = DR_IDLE;
        endcase

        busy_n = (state_n != DR_IDLE);
    end

    uart_tx_core #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_core (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start_c),
        .data   (rd),
        .txd    (txd),
        .done_c (done_c)
    );

endmodule

// File: tb/tb_tx_drain.sv
// Self-checking bench for tx_drain: expected line levels come from UART frame arithmetic.
module tb_tx_drain;

    localparam int CPB    = 4;
    localparam int DEPTH  = 8;
    localparam int AW     = 20;
    localparam int FRAME  = 10 * CPB;
    localparam int PERIOD = FRAME + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic [AW-1:0] wptr;
    logic [AW-1:0] ra;
    logic [7:0]    rd;
    logic          txd;
    logic          busy;
    logic          empty;
    logic          full;

    logic [7:0] mem [0:DEPTH-1];
    logic       trace_txd  [0:511];
    logic       trace_busy [0:511];
    logic [7:0] exp_bytes  [0:7];
    int         checks   = 0;
    int         failures = 0;

    assign rd = mem[ra[2:0]];

    always #5 clk = ~clk;

    tx_drain #(
        .DEPTH       (DEPTH),
        .CLK_PER_BIT (CPB),
        .AW          (AW)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .wptr  (wptr),
        .ra    (ra),
        .rd    (rd),
        .txd   (txd),
        .busy  (busy),
        .empty (empty),
        .full  (full)
    );

    // Line level t cycles into an 8N1 frame of byte b (idle outside the frame).
    function automatic logic frame_bit(input logic [7:0] b, input int t);
        int slot;
        if (t < 0 || t >= FRAME) return 1'b1;
        slot = t / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // n frames of exp_bytes, first start bit at index off, one PERIOD apart.
    function automatic logic exp_line(input int n, input int off, input int i);
        int t;
        for (int k = 0; k < n; k++) begin
            t = i - (off + k * PERIOD);
            if (t >= 0 && t < FRAME) return frame_bit(exp_bytes[k], t);
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int n, input int off, input int i);
        return (i >= off - 1) && (i < off + PERIOD * (n - 1) + FRAME);
    endfunction

    task automatic do_reset();
        en   = 1'b1;
        wptr = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Producer-style update: wptr changes just after a rising edge.
    task automatic drive_wptr(input int v);
        @(posedge clk);
        #1 wptr = AW'(v);
    endtask

    task automatic capture(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            trace_txd[i]  = txd;
            trace_busy[i] = busy;
            if (i == drop_at) en = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({txd, busy, empty, full, ra} !== {1'b1, 1'b0, 1'b1, 1'b0, AW'(0)}) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got txd=%b busy=%b empty=%b full=%b ra=%0d exp 1 0 1 0 0",
                         i, txd, busy, empty, full, ra);
            end
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        int len;
        do_reset();
        mem[0] = b;
        exp_bytes[0] = b;
        drive_wptr(1);
        len = 2 + FRAME + 6;
        capture(len, -1);
        for (int i = 0; i < len; i++) begin
            checks++;
            if (trace_txd[i] !== exp_line(1, 2, i)) begin
                failures++;
                $display("FAIL single_txd byte=%h idx=%0d got=%b exp=%b", b, i, trace_txd[i], exp_line(1, 2, i));
            end
            checks++;
            if (trace_busy[i] !== exp_busy(1, 2, i)) begin
                failures++;
                $display("FAIL single_busy byte=%h idx=%0d got=%b exp=%b", b, i, trace_busy[i], exp_busy(1, 2, i));
            end
        end
        checks++;
        if (ra !== AW'(1) || empty !== 1'b1) begin
            failures++;
            $display("FAIL single_end got ra=%0d empty=%b exp ra=1 empty=1", ra, empty);
        end
    endtask

    // Caller loads exp_bytes[0..n-1]; they are sent from address 0 after reset.
    task automatic test_back_to_back(input int n);
        int len;
        do_reset();
        for (int k = 0; k < n; k++) mem[k] = exp_bytes[k];
        drive_wptr(n);
        len = 2 + PERIOD * (n - 1) + FRAME + 6;
        capture(len, -1);
        for (int i = 0; i < len; i++) begin
            checks++;
            if (trace_txd[i] !== exp_line(n, 2, i)) begin
                failures++;
                $display("FAIL b2b_txd n=%0d idx=%0d got=%b exp=%b", n, i, trace_txd[i], exp_line(n, 2, i));
            end
            checks++;
            if (trace_busy[i] !== exp_busy(n, 2, i)) begin
                failures++;
                $display("FAIL b2b_busy n=%0d idx=%0d got=%b exp=%b", n, i, trace_busy[i], exp_busy(n, 2, i));
            end
        end
        checks++;
        if (ra !== AW'(n % DEPTH) || empty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end got ra=%0d empty=%b exp ra=%0d empty=1", ra, empty, n % DEPTH);
        end
    endtask

    task automatic test_wrap();
        int len;
        do_reset();
        for (int k = 0; k < 6; k++) mem[k] = 8'($urandom);
        drive_wptr(6);
        repeat (6 * PERIOD + 10) @(negedge clk);
        checks++;
        if (ra !== AW'(6) || empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_pre got ra=%0d empty=%b exp ra=6 empty=1", ra, empty);
        end
        mem[6] = 8'($urandom);
        mem[7] = 8'($urandom);
        exp_bytes[0] = mem[6];
        exp_bytes[1] = mem[7];
        drive_wptr(7);
        drive_wptr(0);
        len = 1 + PERIOD + FRAME + 6;
        capture(len, -1);
        for (int i = 0; i < len; i++) begin
            checks++;
            if (trace_txd[i] !== exp_line(2, 1, i)) begin
                failures++;
                $display("FAIL wrap_txd idx=%0d got=%b exp=%b", i, trace_txd[i], exp_line(2, 1, i));
            end
        end
        checks++;
        if (ra !== AW'(0) || empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_end got ra=%0d empty=%b exp ra=0 empty=1", ra, empty);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 7; k++) mem[k] = 8'($urandom);
        drive_wptr(7);
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL full_set got full=%b empty=%b exp full=1 empty=0", full, empty);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (full !== 1'b0 || ra !== AW'(1)) begin
            failures++;
            $display("FAIL full_clear got full=%b ra=%0d exp full=0 ra=1", full, ra);
        end
        repeat (7 * PERIOD + 10) @(negedge clk);
        checks++;
        if (ra !== AW'(7) || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_drain got ra=%0d empty=%b full=%b busy=%b exp 7 1 0 0", ra, empty, full, busy);
        end
    endtask

    task automatic test_en_drop();
        int len;
        do_reset();
        exp_bytes[0] = 8'($urandom);
        exp_bytes[1] = 8'($urandom);
        mem[0] = exp_bytes[0];
        mem[1] = exp_bytes[1];
        drive_wptr(2);
        len = 2 + FRAME + 20;
        capture(len, 2 + 3 * CPB);
        for (int i = 0; i < len; i++) begin
            checks++;
            if (trace_txd[i] !== exp_line(1, 2, i)) begin
                failures++;
                $display("FAIL endrop_txd idx=%0d got=%b exp=%b", i, trace_txd[i], exp_line(1, 2, i));
            end
            checks++;
            if (trace_busy[i] !== exp_busy(1, 2, i)) begin
                failures++;
                $display("FAIL endrop_busy idx=%0d got=%b exp=%b", i, trace_busy[i], exp_busy(1, 2, i));
            end
        end
        checks++;
        if (ra !== AW'(1) || empty !== 1'b0) begin
            failures++;
            $display("FAIL endrop_hold got ra=%0d empty=%b exp ra=1 empty=0", ra, empty);
        end
        en = 1'b1;
        exp_bytes[0] = exp_bytes[1];
        len = 1 + FRAME + 6;
        capture(len, -1);
        for (int i = 0; i < len; i++) begin
            checks++;
            if (trace_txd[i] !== exp_line(1, 1, i)) begin
                failures++;
                $display("FAIL enresume_txd idx=%0d got=%b exp=%b", i, trace_txd[i], exp_line(1, 1, i));
            end
        end
        checks++;
        if (ra !== AW'(2) || empty !== 1'b1) begin
            failures++;
            $display("FAIL enresume_end got ra=%0d empty=%b exp ra=2 empty=1", ra, empty);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        do_reset();
        b = 8'($urandom) & 8'hFE;
        mem[0] = b;
        drive_wptr(1);
        capture(8, -1);
        checks++;
        if (trace_txd[7] !== 1'b0 || trace_busy[7] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got txd=%b busy=%b exp txd=0 busy=1", trace_txd[7], trace_busy[7]);
        end
        #1 rstn = 1'b0;
        wptr = '0;
        #1;
        checks++;
        if (txd !== 1'b1 || ra !== AW'(0) || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async got txd=%b ra=%0d busy=%b exp 1 0 0", txd, ra, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({txd, busy, empty, ra} !== {1'b1, 1'b0, 1'b1, AW'(0)}) begin
                failures++;
                $display("FAIL rstmid_after cyc=%0d got txd=%b busy=%b empty=%b ra=%0d exp 1 0 1 0",
                         i, txd, busy, empty, ra);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0;
        en   = 1'b1;
        wptr = '0;
        for (int k = 0; k < DEPTH; k++) mem[k] = 8'h00;

        test_reset();
        test_single(8'hA5);
        test_single(8'($urandom));
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'hFF;
        exp_bytes[2] = 8'h55;
        test_back_to_back(3);
        n = int'($urandom_range(2, 6));
        for (int k = 0; k < n; k++) exp_bytes[k] = 8'($urandom);
        test_back_to_back(n);
        test_wrap();
        test_full();
        test_en_drop();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
